// File: rtl/rom_responder.sv
// ---------------------------------------------------------------------------
// rom_responder
//
// Bus-side model of a program ROM chip on a nibble-serial CPU bus.
// An instruction cycle has eight phases (A1 A2 A3 M1 M2 X1 X2 X3). The CPU
// sends the 12-bit fetch address as three nibbles in A1..A3. The top nibble
// (A3) selects the chip. When the chip is selected, it returns the program
// byte as OPR (M1) and OPA (M2).
//
// The chip also has a 4-bit I/O port:
//   - SRC (rom_cmd high in X2) selects the chip for I/O.
//   - WRR (opcode E2) loads io_out from the bus in X2.
//   - RDR (opcode EA) drives io_in onto the bus in X2.
//
// Ports
//   clock      in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   halt       in   freeze all registered state
//   sync       in   CPU X3 marker; the next cycle is A1
//   rom_cmd    in   CPU ROM command strobe (SRC in X2, I/O instr in M2)
//   data_i     in   nibble driven by the CPU
//   data_o     out  nibble driven to the CPU (0 when data_en is low)
//   data_en    out  data_o valid
//   rom_addr   out  byte address to the program store {A2, A1}
//   rom_rdata  in   program byte at rom_addr (combinational)
//   io_in      in   I/O input port
//   io_out     out  I/O output port latch
// ---------------------------------------------------------------------------
module rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       halt,
    input  logic       sync,
    input  logic       rom_cmd,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       data_en,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_rdata,
    input  logic [3:0] io_in,
    output logic [3:0] io_out
);

    typedef enum logic [2:0] {
        PhA1 = 3'd0,
        PhA2 = 3'd1,
        PhA3 = 3'd2,
        PhM1 = 3'd3,
        PhM2 = 3'd4,
        PhX1 = 3'd5,
        PhX2 = 3'd6,
        PhX3 = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        IoNone = 2'd0,
        IoWrr  = 2'd1,
        IoRdr  = 2'd2
    } io_op_e;

    localparam logic [3:0] OprIo  = 4'hE;
    localparam logic [3:0] OpaWrr = 4'h2;
    localparam logic [3:0] OpaRdr = 4'hA;

    // Registered state
    logic       locked_q,    locked_d;
    phase_e     phase_q,     phase_d;
    logic [7:0] rom_addr_q,  rom_addr_d;
    logic       fetch_sel_q, fetch_sel_d;
    logic [3:0] opr_q,       opr_d;
    io_op_e     io_op_q,     io_op_d;
    logic       src_sel_q,   src_sel_d;
    logic [3:0] io_out_q,    io_out_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        locked_d    = locked_q;
        phase_d     = phase_q;
        rom_addr_d  = rom_addr_q;
        fetch_sel_d = fetch_sel_q;
        opr_d       = opr_q;
        io_op_d     = io_op_q;
        src_sel_d   = src_sel_q;
        io_out_d    = io_out_q;

        if (!halt) begin
            // Phase work happens only when aligned. When unlocked, nothing is latched.
            if (locked_q) begin
                case (phase_q)
                    PhA1: rom_addr_d[3:0] = data_i;
                    PhA2: rom_addr_d[7:4] = data_i;
                    PhA3: fetch_sel_d     = (data_i == CHIP_ID);
                    PhM1: begin
                        if (fetch_sel_q) begin
                            opr_d = rom_rdata[7:4];
                        end
                    end
                    PhM2: begin
                        io_op_d = IoNone;
                        if (rom_cmd && fetch_sel_q && (opr_q == OprIo)) begin
                            if (rom_rdata[3:0] == OpaWrr) begin
                                io_op_d = IoWrr;
                            end else if (rom_rdata[3:0] == OpaRdr) begin
                                io_op_d = IoRdr;
                            end
                        end
                    end
                    PhX2: begin
                        // rom_cmd in X2 is an SRC. A WRR never shares its X2 with an SRC.
                        if (rom_cmd) begin
                            src_sel_d = (data_i == CHIP_ID);
                        end else if ((io_op_q == IoWrr) && src_sel_q) begin
                            io_out_d = data_i;
                        end
                    end
                    PhX3: io_op_d = IoNone;
                    default: ;
                endcase

                // X3 wraps to A1 even if sync is missed.
                phase_d = phase_e'(phase_q + 3'd1);
            end

            // sync overrides the phase from any state. This also locks after reset.
            if (sync) begin
                locked_d = 1'b1;
                phase_d  = PhA1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_q    <= 1'b0;
            phase_q     <= PhA1;
            rom_addr_q  <= 8'h00;
            fetch_sel_q <= 1'b0;
            opr_q       <= 4'h0;
            io_op_q     <= IoNone;
            src_sel_q   <= 1'b0;
            io_out_q    <= 4'h0;
        end else begin
            locked_q    <= locked_d;
            phase_q     <= phase_d;
            rom_addr_q  <= rom_addr_d;
            fetch_sel_q <= fetch_sel_d;
            opr_q       <= opr_d;
            io_op_q     <= io_op_d;
            src_sel_q   <= src_sel_d;
            io_out_q    <= io_out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Bus drive
    // -----------------------------------------------------------------------
    // Drive enables come only from registered state. This keeps them constant
    // for the whole phase, including while halted.
    // Reset clears locked_q at once, so any drive in progress is dropped at once.
    always_comb begin
        data_en = 1'b0;
        data_o  = 4'h0;
        if (locked_q) begin
            case (phase_q)
                PhM1: begin
                    if (fetch_sel_q) begin
                        data_en = 1'b1;
                        data_o  = rom_rdata[7:4];
                    end
                end
                PhM2: begin
                    if (fetch_sel_q) begin
                        data_en = 1'b1;
                        data_o  = rom_rdata[3:0];
                    end
                end
                PhX2: begin
                    if ((io_op_q == IoRdr) && src_sel_q) begin
                        data_en = 1'b1;
                        data_o  = io_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign io_out   = io_out_q;

endmodule

// File: tb/tb_rom_responder.sv
// ---------------------------------------------------------------------------
// tb_rom_responder
//
// Instruction-level checker for rom_responder with CHIP_ID=3.
// The bench runs whole eight-phase instructions. It computes the expected
// bus drive for each phase from the instruction fields. A small model tracks
// the chip-select and port state that carries over between instructions.
// ---------------------------------------------------------------------------
module tb_rom_responder;

    localparam logic [3:0] CHIP = 4'h3;

    logic       clock;
    logic       reset_n;
    logic       halt;
    logic       sync;
    logic       rom_cmd;
    logic [3:0] data_i;
    logic [3:0] data_o;
    logic       data_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_rdata;
    logic [3:0] io_in;
    logic [3:0] io_out;

    int checks   = 0;
    int failures = 0;

    // Reference state that survives across instructions
    logic       m_src_sel;
    logic [3:0] m_io_out;

    typedef struct {
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] a3;
        logic [7:0] rom;
        logic       m2cmd;
        logic       x2cmd;
        logic [3:0] x2nib;
        logic [3:0] ioin;
    } instr_t;

    rom_responder #(
        .CHIP_ID(CHIP)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .halt     (halt),
        .sync     (sync),
        .rom_cmd  (rom_cmd),
        .data_i   (data_i),
        .data_o   (data_o),
        .data_en  (data_en),
        .rom_addr (rom_addr),
        .rom_rdata(rom_rdata),
        .io_in    (io_in),
        .io_out   (io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // A single sync pulse makes the next cycle A1.
    task automatic do_sync();
        sync    = 1'b1;
        halt    = 1'b0;
        rom_cmd = 1'b0;
        next_cycle();
        sync = 1'b0;
    endtask

    // Reset in the middle of an instruction. The bus must go quiet at once and
    // stay quiet until a sync arrives.
    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_en_now", 8'(data_en), 8'h00);
        check_eq("rst_do_now", 8'(data_o), 8'h00);
        check_eq("rst_addr", rom_addr, 8'h00);
        check_eq("rst_io_out", 8'(io_out), 8'h00);
        m_src_sel = 1'b0;
        m_io_out  = 4'h0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i    = 4'($urandom);
            rom_cmd   = 1'($urandom);
            rom_rdata = 8'hE2;
            sync      = 1'b0;
            @(negedge clock);
            check_eq("unlocked_en", 8'(data_en), 8'h00);
            next_cycle();
        end
    endtask

    // Run one instruction that starts in A1.
    //   halt_p:   phase held for 3 extra halted cycles (-1 = none)
    //   resync_p: phase that carries an early sync, after which the
    //             instruction ends (-1 = none)
    //   reset_p:  phase where reset hits (-1 = none)
    task automatic run_instr(input instr_t t, input int halt_p, input int resync_p,
                             input int reset_p);
        logic       sel;
        logic       iorun;
        logic       wrr;
        logic       rdr;
        logic       exp_en;
        logic [3:0] exp_do;
        sel   = (t.a3 == CHIP);
        iorun = t.m2cmd && sel && (t.rom[7:4] == 4'hE);
        wrr   = iorun && (t.rom[3:0] == 4'h2);
        rdr   = iorun && (t.rom[3:0] == 4'hA);
        for (int p = 0; p < 8; p++) begin
            case (p)
                0: data_i = t.a1;
                1: data_i = t.a2;
                2: data_i = t.a3;
                6: data_i = t.x2nib;
                default: data_i = 4'($urandom);
            endcase
            if (p == 4) begin
                rom_cmd = t.m2cmd;
            end else if (p == 6) begin
                rom_cmd = t.x2cmd;
            end else begin
                rom_cmd = 1'($urandom);
            end
            rom_rdata = t.rom;
            io_in     = t.ioin;
            sync      = (p == 7) || (p == resync_p);
            halt      = 1'b0;

            exp_en = 1'b0;
            exp_do = 4'h0;
            if (p == 3 && sel) begin
                exp_en = 1'b1;
                exp_do = t.rom[7:4];
            end else if (p == 4 && sel) begin
                exp_en = 1'b1;
                exp_do = t.rom[3:0];
            end else if (p == 6 && rdr && m_src_sel) begin
                exp_en = 1'b1;
                exp_do = t.ioin;
            end

            if (p == halt_p) begin
                halt = 1'b1;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clock);
                    check_eq("halt_en", 8'(data_en), 8'(exp_en));
                    check_eq("halt_do", 8'(data_o), 8'(exp_do));
                    next_cycle();
                end
                halt = 1'b0;
            end

            @(negedge clock);
            check_eq("bus_en", 8'(data_en), 8'(exp_en));
            check_eq("bus_do", 8'(data_o), 8'(exp_do));
            if (p == 3) begin
                check_eq("rom_addr", rom_addr, {t.a2, t.a1});
            end
            if (p == reset_p) begin
                mid_reset();
                return;
            end
            next_cycle();

            if (p == 6) begin
                if (t.x2cmd) begin
                    m_src_sel = (t.x2nib == CHIP);
                end else if (wrr && m_src_sel) begin
                    m_io_out = t.x2nib;
                end
            end
            if (p == resync_p) begin
                sync = 1'b0;
                return;
            end
        end
        sync = 1'b0;
        check_eq("io_out", 8'(io_out), 8'(m_io_out));
    endtask

    function automatic instr_t mk(input logic [3:0] a1, input logic [3:0] a2,
                                  input logic [3:0] a3, input logic [7:0] rom,
                                  input logic m2cmd, input logic x2cmd,
                                  input logic [3:0] x2nib, input logic [3:0] ioin);
        instr_t t;
        t.a1 = a1; t.a2 = a2; t.a3 = a3; t.rom = rom;
        t.m2cmd = m2cmd; t.x2cmd = x2cmd; t.x2nib = x2nib; t.ioin = ioin;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        logic [3:0] opa;
        t.a1 = 4'($urandom);
        t.a2 = 4'($urandom);
        t.a3 = ($urandom_range(0, 1) == 0) ? CHIP : 4'($urandom);
        case ($urandom_range(0, 3))
            0: opa = 4'h2;
            1: opa = 4'hA;
            default: opa = 4'($urandom);
        endcase
        t.rom   = {(($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom)), opa};
        t.m2cmd = 1'($urandom);
        t.x2nib = ($urandom_range(0, 1) == 0) ? CHIP : 4'($urandom);
        t.ioin  = 4'($urandom);
        // An SRC never shares X2 with an I/O instruction.
        if (t.m2cmd && (t.a3 == CHIP) && (t.rom[7:4] == 4'hE)) begin
            t.x2cmd = 1'b0;
        end else begin
            t.x2cmd = ($urandom_range(0, 3) == 0);
        end
        return t;
    endfunction

    initial begin
        reset_n   = 1'b0;
        halt      = 1'b0;
        sync      = 1'b0;
        rom_cmd   = 1'b0;
        data_i    = 4'h0;
        rom_rdata = 8'h00;
        io_in     = 4'h0;
        m_src_sel = 1'b0;
        m_io_out  = 4'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("reset_en", 8'(data_en), 8'h00);
        check_eq("reset_do", 8'(data_o), 8'h00);
        check_eq("reset_addr", rom_addr, 8'h00);
        check_eq("reset_io_out", 8'(io_out), 8'h00);
        @(posedge clock);
        #2;
        reset_n = 1'b1;

        // Unlocked: the bus stays silent and nothing is latched.
        for (int i = 0; i < 8; i++) begin
            data_i    = 4'h3;
            rom_cmd   = 1'b1;
            rom_rdata = 8'hFF;
            @(negedge clock);
            check_eq("idle_en", 8'(data_en), 8'h00);
            check_eq("idle_addr", rom_addr, 8'h00);
            next_cycle();
        end

        do_sync();

        // Basic fetch.
        run_instr(mk(4'h5, 4'hA, 4'h3, 8'hD7, 1'b0, 1'b0, 4'h0, 4'h0), -1, -1, -1);
        // A chip-number mismatch stays silent. The next matching fetch drives.
        run_instr(mk(4'h5, 4'hA, 4'h2, 8'hD7, 1'b0, 1'b0, 4'h0, 4'h0), -1, -1, -1);
        run_instr(mk(4'h1, 4'h2, 4'h3, 8'hD7, 1'b0, 1'b0, 4'h0, 4'h0), -1, -1, -1);
        // SRC selects this chip, then WRR loads the port.
        run_instr(mk(4'h0, 4'h1, 4'h3, 8'h21, 1'b0, 1'b1, 4'h3, 4'h0), -1, -1, -1);
        run_instr(mk(4'h2, 4'h1, 4'h3, 8'hE2, 1'b1, 1'b0, 4'h9, 4'h0), -1, -1, -1);
        check_eq("wrr_loaded", 8'(io_out), 8'h09);
        // SRC selects another chip, so WRR is ignored.
        run_instr(mk(4'h4, 4'h1, 4'h3, 8'h21, 1'b0, 1'b1, 4'h4, 4'h0), -1, -1, -1);
        run_instr(mk(4'h6, 4'h1, 4'h3, 8'hE2, 1'b1, 1'b0, 4'h5, 4'h0), -1, -1, -1);
        check_eq("wrr_ignored", 8'(io_out), 8'h09);
        // RDR returns io_in in X2.
        run_instr(mk(4'h8, 4'h1, 4'h3, 8'h21, 1'b0, 1'b1, 4'h3, 4'h0), -1, -1, -1);
        run_instr(mk(4'h9, 4'h1, 4'h3, 8'hEA, 1'b1, 1'b0, 4'h0, 4'h6), -1, -1, -1);
        // Early sync in M2, then a normal instruction that must start in A1.
        run_instr(mk(4'hC, 4'h4, 4'h3, 8'h5B, 1'b0, 1'b0, 4'h0, 4'h0), -1, 4, -1);
        run_instr(mk(4'hD, 4'h7, 4'h3, 8'h6C, 1'b0, 1'b0, 4'h0, 4'h0), -1, -1, -1);
        // Halt for 3 cycles in M1.
        run_instr(mk(4'h3, 4'h3, 4'h3, 8'hB4, 1'b0, 1'b0, 4'h0, 4'h0), 3, -1, -1);
        // Reset in M1. The bus stays quiet until the next sync.
        run_instr(mk(4'h3, 4'h3, 4'h3, 8'hB4, 1'b0, 1'b0, 4'h0, 4'h0), -1, -1, 3);
        do_sync();

        // Random instruction stream with occasional halts.
        for (int n = 0; n < 300; n++) begin
            int hp;
            hp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(rand_instr(), hp, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_responder.md
ROM_RESPONDER -- requirements
Module: rom_responder

Interface
REQ-001 Parameter CHIP_ID, default 4'h0, is the 4-bit ROM chip number matched for fetch and I/O select.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 halt  input  1  freeze: when high, all registered state holds.
REQ-005 sync  input  1  from CPU; high during X3, so the next cycle is A1.
REQ-006 rom_cmd  input  1  from CPU; marks SRC (in X2) and I/O instructions (in M2).
REQ-007 data_i  input  4  CPU-driven bus nibble (CPU data_o).
REQ-008 data_o  output  4  nibble driven to the CPU; 4'h0 when data_en is low.
REQ-009 data_en  output  1  high when data_o is valid for the CPU.
REQ-010 rom_addr  output  8  byte address to the external program store, {A2 nibble, A1 nibble}.
REQ-011 rom_rdata  input  8  program byte at rom_addr; combinational, valid during M1/M2.
REQ-012 io_in  input  4  ROM I/O input port.
REQ-013 io_out  output  4  ROM I/O output port latch.

Function
REQ-014 A 3-bit phase counter SHALL track A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-015 State SHALL be either UNLOCKED or LOCKED; after reset it is UNLOCKED, and the block drives nothing and latches nothing.
REQ-016 On any edge where sync=1 and halt=0, the block SHALL become LOCKED with phase=A1 on the next cycle, whatever the current phase (resync).
REQ-017 When LOCKED and sync=0, the phase SHALL increment modulo 8 (X3 wraps to A1 even if sync is missing).
REQ-018 At the end of A1 and A2, data_i SHALL be latched into rom_addr[3:0] and rom_addr[7:4] respectively.
REQ-019 At the end of A3, fetch_sel SHALL be set to (data_i == CHIP_ID).
REQ-020 In M1 with fetch_sel=1: data_o = rom_rdata[7:4] (OPR) and data_en=1.
REQ-021 In M2 with fetch_sel=1: data_o = rom_rdata[3:0] (OPA) and data_en=1.
REQ-022 At the end of M1 with fetch_sel=1, rom_rdata[7:4] SHALL be latched as opr.
REQ-023 At the end of M2, io_op SHALL be set only if rom_cmd=1, fetch_sel=1 and opr=4'hE.
  - WRR when rom_rdata[3:0]=4'h2.
  - RDR when rom_rdata[3:0]=4'hA.
  - Otherwise none.
REQ-024 At the end of X2 with rom_cmd=1 (SRC), src_sel SHALL be set to (data_i == CHIP_ID); src_sel holds until the next SRC or reset.
REQ-025 WRR: at the end of X2, when io_op=WRR, src_sel=1 and rom_cmd=0, io_out SHALL load data_i.
REQ-026 RDR: during X2, when io_op=RDR and src_sel=1, data_o = io_in and data_en=1.
REQ-027 io_op SHALL clear at the end of X3; an SRC and an I/O action never occur in the same X2.
REQ-028 data_en SHALL be 0 in all phases and cases not listed in REQ-020, REQ-021 and REQ-026, and whenever UNLOCKED.
REQ-029 data_o and data_en SHALL be decoded from registered state only, so they are stable for the whole phase.
REQ-030 While halt=1, phase, latches and io_out SHALL hold, and data_o/data_en keep their current-phase values.
REQ-031 A non-matching A3 nibble (fetch_sel=0) SHALL keep data_en low in M1/M2 and block io_op.

Reset
REQ-032 reset_n=0 SHALL asynchronously set the following, with no glitch on deassertion:
  - state=UNLOCKED, phase=A1.
  - rom_addr=8'h00, fetch_sel=0, opr=4'h0, io_op=none, src_sel=0.
  - io_out=4'h0, data_en=0, data_o=4'h0.
REQ-033 Reset asserted mid-instruction SHALL abort any drive immediately, and the block waits for the next sync.

Verification
REQ-034 Fetch: CHIP_ID=3, sync, then A1=5, A2=A, A3=3, rom_rdata=8'hD7 -> rom_addr=8'hA5 from M1; data_o=D/en=1 in M1; 7/en=1 in M2; en=0 in X1-X3.
REQ-035 Deselect: same as REQ-034 but A3=2 -> data_en=0 for the whole instruction; the following instruction with A3=3 drives normally.
REQ-036 SRC+WRR: rom_cmd=1 with X2 bus=3, then a fetch of 8'hE2 with rom_cmd=1 in M2 and X2 bus=9 -> io_out=9; with an SRC nibble of 4 instead, io_out is unchanged.
REQ-037 RDR: src_sel=1, fetch 8'hEA with rom_cmd in M2, io_in=6 -> data_o=6/en=1 in X2 only.
REQ-038 Resync and halt:
  - sync pulsed at phase M2 -> next cycle is A1.
  - halt held 3 cycles in M1 -> data_o/en held, then M2 follows.
  - reset_n pulsed in M1 -> en=0 at once, and no drive until the next sync.
